// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the execute/memory-side writeback signals, the decode hazard
// query and the regfile write port served by regfile_wb_arbiter.
interface regfile_wb_arbiter_if;
    // ALU writeback (never back-pressured)
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    // Load issue (scoreboard set) and load return
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    // Decode hazard query
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    // Regfile write port
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    // Sticky load-drop error
    logic        overflow;

    // Pipeline side: produces results and queries hazards
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        output rs1, rs2,
        input  ld_ready, stall, write, wrAddr, wrData, overflow
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        input  rs1, rs2,
        output ld_ready, stall, write, wrAddr, wrData, overflow
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: ALU results win the single write port, load
// results queue in a small FIFO and drain when the port is free. A 32-entry
// pending-load scoreboard raises a combinational decode stall on hazards.
module regfile_wb_arbiter #(
    parameter int LD_DEPTH = 2,
    parameter int PTR_W    = 1
) (
    input logic                  clk,
    input logic                  reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LD_DEPTH);

    // FIFO storage (no reset needed; validity is tracked by count)
    logic [4:0]  fifo_rd_mem   [LD_DEPTH];
    logic [31:0] fifo_data_mem [LD_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic        write_q,   write_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] pending_q, pending_d;
    logic        overflow_q, overflow_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        alu_take;
    logic        pop;
    logic        push_req;
    logic        push;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    // Port arbitration and FIFO push/pop decisions
    always_comb begin
        fifo_full  = (count_q == DEPTH_CNT);
        fifo_empty = (count_q == '0);
        head_rd    = fifo_rd_mem[rd_ptr_q];
        head_data  = fifo_data_mem[rd_ptr_q];
        // rd=0 ALU results are architecturally dead, so they leave the port free
        alu_take   = bus.alu_valid && (bus.alu_rd != 5'd0);
        pop        = !alu_take && !fifo_empty;
        push_req   = bus.ld_valid && (bus.ld_rd != 5'd0);
        // A full FIFO still accepts when its head leaves on the same edge
        push       = push_req && (!fifo_full || pop);
    end

    // Next-state for pointers, count, write port, scoreboard and error flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        write_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (alu_take) begin
            write_d   = 1'b1;
            wr_addr_d = bus.alu_rd;
            wr_data_d = bus.alu_data;
        end else if (pop) begin
            write_d   = 1'b1;
            wr_addr_d = head_rd;
            wr_data_d = head_data;
        end

        // Clear first so a same-cycle issue to the same register wins
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) begin
            pending_d[bus.ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            write_q    <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
            pending_q  <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            write_q    <= write_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write on accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= bus.ld_rd;
            fifo_data_mem[wr_ptr_q] <= bus.ld_data;
        end
    end

    assign bus.write    = write_q;
    assign bus.wrAddr   = wr_addr_q;
    assign bus.wrData   = wr_data_q;
    assign bus.overflow = overflow_q;
    assign bus.ld_ready = !fifo_full;
    assign bus.stall    = ((bus.rs1 != 5'd0) && pending_q[bus.rs1]) ||
                          ((bus.rs2 != 5'd0) && pending_q[bus.rs2]);

endmodule
